// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop sync, per-bit debounce, press pulse.
// Optional auto-repeat on masked bits when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner #(
   parameter int unsigned       N_BTN           = 6,
   parameter int unsigned       DEBOUNCE_CYCLES = 1250000,
   parameter logic [N_BTN-1:0]  REPEAT_MASK     = 6'b011000,
   parameter int unsigned       REPEAT_DELAY    = 62500000,
   parameter int unsigned       REPEAT_PERIOD   = 25000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef BUTTON_AUTOREPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                  REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned TW   = $clog2(RMAX + 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HELD,
      ST_REPEAT
   } state_e;

   logic [N_BTN-1:0] s1_q;
   logic [N_BTN-1:0] s2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= btn_raw;
         s2_q <= s1_q;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      logic [CW-1:0] cnt_q, cnt_d;
      logic          lvl_q, lvl_d;
      logic          pls_q, pls_d;
      logic          rise, fall;
      state_e        st_q, st_d;
`ifdef BUTTON_AUTOREPEAT_EN
      logic [TW-1:0] tmr_q, tmr_d;
`endif

      always_comb begin
         cnt_d = '0;
         lvl_d = lvl_q;
         rise  = 1'b0;
         fall  = 1'b0;
         if (s2_q[i] != lvl_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
               lvl_d = s2_q[i];
               rise  = s2_q[i];
               fall  = ~s2_q[i];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      // Release is tested first so it beats a repeat firing on the same edge.
      always_comb begin
         st_d  = st_q;
         pls_d = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
         tmr_d = tmr_q + 1'b1;
`endif
         unique case (st_q)
            ST_IDLE: begin
`ifdef BUTTON_AUTOREPEAT_EN
               tmr_d = '0;
`endif
               if (rise) begin
                  st_d  = ST_HELD;
                  pls_d = 1'b1;
               end
            end
            ST_HELD: begin
               if (fall) begin
                  st_d = ST_IDLE;
`ifdef BUTTON_AUTOREPEAT_EN
                  tmr_d = '0;
               end else if (REPEAT_MASK[i] &&
                            tmr_q == TW'(REPEAT_DELAY - 1)) begin
                  st_d  = ST_REPEAT;
                  pls_d = 1'b1;
                  tmr_d = '0;
`endif
               end
            end
            ST_REPEAT: begin
               if (fall) begin
                  st_d = ST_IDLE;
`ifdef BUTTON_AUTOREPEAT_EN
                  tmr_d = '0;
               end else if (tmr_q == TW'(REPEAT_PERIOD - 1)) begin
                  pls_d = 1'b1;
                  tmr_d = '0;
`endif
               end
            end
            default: st_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
            pls_q <= 1'b0;
            st_q  <= ST_IDLE;
`ifdef BUTTON_AUTOREPEAT_EN
            tmr_q <= '0;
`endif
         end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
            pls_q <= pls_d;
            st_q  <= st_d;
`ifdef BUTTON_AUTOREPEAT_EN
            tmr_q <= tmr_d;
`endif
         end
      end

      assign btn_level[i] = lvl_q;
      assign btn_pulse[i] = pls_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (debounce 4, delay 10, period 3).
// Repeat expectations follow BUTTON_AUTOREPEAT_EN.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] btn_raw;
   logic [5:0] btn_level;
   logic [5:0] btn_pulse;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .N_BTN(6),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_MASK(6'b011000),
      .REPEAT_DELAY(10),
      .REPEAT_PERIOD(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .btn_level(btn_level),
      .btn_pulse(btn_pulse)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [5:0] el, ep;
      reset = 1'b1;
      btn_raw = 6'h3F;
      #1;
      checks++;
      if (btn_level !== 6'h00 || btn_pulse !== 6'h00) begin
         errors++;
         $display("FAIL reset_t0 lvl=%h pls=%h exp 00/00",
                  btn_level, btn_pulse);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (btn_level !== 6'h00 || btn_pulse !== 6'h00) begin
            errors++;
            $display("FAIL reset_hold c%0d lvl=%h pls=%h exp 00/00",
                     c, btn_level, btn_pulse);
         end
      end
      reset = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         step();
         el = (c >= 6) ? 6'h3F : 6'h00;
         ep = (c == 6) ? 6'h3F : 6'h00;
         checks++;
         if (btn_level !== el || btn_pulse !== ep) begin
            errors++;
            $display("FAIL reset_release c%0d lvl=%h pls=%h exp %h/%h",
                     c, btn_level, btn_pulse, el, ep);
         end
      end
      btn_raw = 6'h00;
      for (int c = 1; c <= 8; c++) begin
         step();
         checks++;
         if (btn_pulse !== 6'h00) begin
            errors++;
            $display("FAIL reset_drop c%0d pls=%h exp 00", c, btn_pulse);
         end
      end
      checks++;
      if (btn_level !== 6'h00) begin
         errors++;
         $display("FAIL reset_drop_lvl lvl=%h exp 00", btn_level);
      end
   endtask

   task automatic test_clean_press();
      int extra = 0;
      btn_raw = 6'h01;
      for (int c = 1; c <= 6; c++) begin
         step();
         checks++;
         if (c < 6 && (btn_level !== 6'h00 || btn_pulse !== 6'h00)) begin
            errors++;
            $display("FAIL press_early c%0d lvl=%h pls=%h exp 00/00",
                     c, btn_level, btn_pulse);
         end
         if (c == 6 && (btn_level !== 6'h01 || btn_pulse !== 6'h01)) begin
            errors++;
            $display("FAIL press_accept lvl=%h pls=%h exp 01/01",
                     btn_level, btn_pulse);
         end
      end
      for (int c = 7; c <= 20; c++) begin
         step();
         if (btn_pulse !== 6'h00) extra++;
      end
      btn_raw = 6'h00;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (btn_pulse !== 6'h00) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL press_extra_pulses got %0d exp 0", extra);
      end
      checks++;
      if (btn_level !== 6'h00) begin
         errors++;
         $display("FAIL press_release_lvl lvl=%h exp 00", btn_level);
      end
   endtask

   task automatic test_bounce();
      bit pat [0:4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      int extra = 0;
      for (int j = 0; j < 5; j++) begin
         btn_raw[2] = pat[j];
         step();
         if (btn_pulse !== 6'h00 || btn_level !== 6'h00) extra++;
      end
      btn_raw[2] = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step();
         if (btn_pulse !== 6'h00 || btn_level !== 6'h00) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL bounce_early got %0d bad cycles exp 0", extra);
      end
      step();
      checks++;
      if (btn_level !== 6'h04 || btn_pulse !== 6'h04) begin
         errors++;
         $display("FAIL bounce_accept lvl=%h pls=%h exp 04/04",
                  btn_level, btn_pulse);
      end
      step();
      checks++;
      if (btn_pulse !== 6'h00) begin
         errors++;
         $display("FAIL bounce_single pls=%h exp 00", btn_pulse);
      end
      btn_raw = 6'h00;
      for (int c = 1; c <= 10; c++) step();
      extra = 0;
      btn_raw[2] = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         step();
         if (btn_pulse !== 6'h00 || btn_level !== 6'h00) extra++;
      end
      btn_raw[2] = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (btn_pulse !== 6'h00 || btn_level !== 6'h00) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL short_glitch got %0d bad cycles exp 0", extra);
      end
   endtask

   task automatic test_simultaneous();
      int extra = 0;
      btn_raw = 6'h21;
      for (int c = 1; c <= 5; c++) begin
         step();
         if (btn_pulse !== 6'h00) extra++;
      end
      step();
      checks++;
      if (btn_pulse !== 6'h21 || btn_level !== 6'h21 || extra != 0) begin
         errors++;
         $display("FAIL simul_accept lvl=%h pls=%h early=%0d exp 21/21/0",
                  btn_level, btn_pulse, extra);
      end
      step();
      checks++;
      if (btn_pulse !== 6'h00) begin
         errors++;
         $display("FAIL simul_single pls=%h exp 00", btn_pulse);
      end
      btn_raw = 6'h00;
      for (int c = 1; c <= 10; c++) step();
   endtask

   task automatic test_repeat();
      logic [5:0] el, ep;
      int n3 = 0;
      int n0 = 0;
      int exp3;
      btn_raw = 6'h09;
      for (int c = 1; c <= 6; c++) step();
      checks++;
      if (btn_level !== 6'h09 || btn_pulse !== 6'h09) begin
         errors++;
         $display("FAIL rep_accept lvl=%h pls=%h exp 09/09",
                  btn_level, btn_pulse);
      end
      n3 = btn_pulse[3];
      n0 = btn_pulse[0];
      for (int j = 1; j <= 40; j++) begin
         step();
         el = (j < 31) ? 6'h09 : 6'h00;
         ep = 6'h00;
`ifdef BUTTON_AUTOREPEAT_EN
         if (j >= 10 && j <= 28 && ((j - 10) % 3) == 0) ep = 6'h08;
`endif
         checks++;
         if (btn_level !== el || btn_pulse !== ep) begin
            errors++;
            $display("FAIL rep_a+%0d lvl=%h pls=%h exp %h/%h",
                     j, btn_level, btn_pulse, el, ep);
         end
         n3 += int'(btn_pulse[3]);
         n0 += int'(btn_pulse[0]);
         if (j == 25) btn_raw = 6'h00;
      end
`ifdef BUTTON_AUTOREPEAT_EN
      exp3 = 8;
`else
      exp3 = 1;
`endif
      checks++;
      if (n3 != exp3 || n0 != 1) begin
         errors++;
         $display("FAIL rep_counts btn3=%0d btn0=%0d exp %0d/1",
                  n3, n0, exp3);
      end
   endtask

   task automatic test_reset_mid_hold();
      logic [5:0] el, ep;
      btn_raw = 6'h08;
      for (int c = 1; c <= 6; c++) step();
      for (int c = 1; c <= 15; c++) step();
      checks++;
      if (btn_level !== 6'h08) begin
         errors++;
         $display("FAIL midhold_pre lvl=%h exp 08", btn_level);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (btn_level !== 6'h00 || btn_pulse !== 6'h00) begin
         errors++;
         $display("FAIL midhold_async lvl=%h pls=%h exp 00/00",
                  btn_level, btn_pulse);
      end
      step();
      step();
      reset = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         step();
         el = (c >= 6) ? 6'h08 : 6'h00;
         ep = (c == 6) ? 6'h08 : 6'h00;
         checks++;
         if (btn_level !== el || btn_pulse !== ep) begin
            errors++;
            $display("FAIL midhold_requal c%0d lvl=%h pls=%h exp %h/%h",
                     c, btn_level, btn_pulse, el, ep);
         end
      end
      btn_raw = 6'h00;
      for (int c = 1; c <= 10; c++) step();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_repeat();
      test_reset_mid_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
